// File: rtl/vi_pkg.sv
// Shared types and sizing for the vectored interrupt controller.
package vi_pkg;

  localparam int NUM_IRQ = 4;
  localparam int ID_W    = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PEND    = 2'd1,
    SERVICE = 2'd2
  } vi_state_e;

  function automatic logic [NUM_IRQ-1:0] id_onehot(input logic [ID_W-1:0] id);
    logic [NUM_IRQ-1:0] oh;
    oh     = '0;
    oh[id] = 1'b1;
    return oh;
  endfunction

  // Ids strictly lower (higher priority) than the given id.
  function automatic logic [NUM_IRQ-1:0] below_mask(input logic [ID_W-1:0] id);
    return id_onehot(id) - {{(NUM_IRQ-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/vi_prio_pick.sv
// Combinational winner select: first eligible id searched cyclically from start_id.
// Zero latency; no flow control.
module vi_prio_pick
  import vi_pkg::*;
(
  input  logic [NUM_IRQ-1:0] elig,
  input  logic [ID_W-1:0]    start_id,
  output logic               win_vld,
  output logic [ID_W-1:0]    win_id
);

  logic [ID_W-1:0] idx;

  // Walk from the farthest offset down so the nearest eligible id is assigned last.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    idx     = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      idx = start_id + ID_W'(k);
      if (elig[idx]) begin
        win_vld = 1'b1;
        win_id  = idx;
      end
    end
  end

endmodule

// File: rtl/vector_interrupt_ctrl.sv
// Vectored interrupt controller feeding a microsequencer D input and CC condition.
// IRQ -> CC_N low in 2 cycles; IACK one cycle after the vectoring edge; sequencer paces via VECT_N/EOI.
// Optional cyclic arbitration with macro VI_ROUND_ROBIN_EN (nesting disabled in that build).
module vector_interrupt_ctrl
  import vi_pkg::*;
#(
  parameter logic [1:0] VEC_BASE = 2'b10
) (
  input  logic                CP,
  input  logic                RESET_N,
  input  logic [NUM_IRQ-1:0]  IRQ,
  input  logic                MASK_WE,
  input  logic [NUM_IRQ-1:0]  MASK_IN,
  input  logic                PL_N,
  input  logic                MAP_N,
  input  logic                VECT_N,
  input  logic [3:0]          PIPE_D,
  input  logic [3:0]          MAP_D,
  input  logic                EOI,
  output logic [3:0]          D_OUT,
  output logic                CC_N,
  output logic [NUM_IRQ-1:0]  IACK,
  output logic [2:0]          ACTIVE
);

  vi_state_e          state, state_nxt;
  logic [NUM_IRQ-1:0] pend;
  logic [NUM_IRQ-1:0] mask;
  logic [NUM_IRQ-1:0] iack_q;
  logic               active_vld;
  logic [ID_W-1:0]    active_id;

  logic [NUM_IRQ-1:0] elig_base;
  logic [NUM_IRQ-1:0] nest_ok;
  logic [NUM_IRQ-1:0] elig;
  logic [ID_W-1:0]    start_id;
  logic               win_vld;
  logic [ID_W-1:0]    win_id;
  logic               vect_sel;
  logic               ack;
  logic               preempt;

  assign elig_base = pend & ~mask;

`ifdef VI_ROUND_ROBIN_EN
  logic [ID_W-1:0] last_id;

  always_ff @(posedge CP or negedge RESET_N) begin
    if (!RESET_N) begin
      last_id <= '1;
    end else if (ack) begin
      last_id <= win_id;
    end
  end

  assign start_id = last_id + 1'b1;
  assign nest_ok  = '1;
  assign preempt  = 1'b0;
`else
  assign start_id = '0;
  // While servicing, only strictly higher-priority requests may break in.
  assign nest_ok  = (state == SERVICE && active_vld) ? below_mask(active_id) : '1;
  assign preempt  = |elig;
`endif

  assign elig = elig_base & nest_ok;

  vi_prio_pick u_pick (
    .elig     (elig),
    .start_id (start_id),
    .win_vld  (win_vld),
    .win_id   (win_id)
  );

  // The vector is only on D when no higher-priority source owns the bus.
  assign vect_sel = PL_N && MAP_N && !VECT_N;
  assign ack      = (state == PEND) && vect_sel && win_vld;

  always_comb begin
    D_OUT = 4'h0;
    if (!PL_N) begin
      D_OUT = PIPE_D;
    end else if (!MAP_N) begin
      D_OUT = MAP_D;
    end else if (!VECT_N && state == PEND && win_vld) begin
      D_OUT = {VEC_BASE, win_id};
    end
  end

  assign CC_N   = !((state == PEND) && (|elig));
  assign IACK   = iack_q;
  assign ACTIVE = {active_vld, active_id};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (|elig) state_nxt = PEND;
      end
      PEND: begin
        if (ack)         state_nxt = SERVICE;
        else if (!(|elig)) state_nxt = IDLE;
      end
      SERVICE: begin
        if (EOI)          state_nxt = (|elig_base) ? PEND : IDLE;
        else if (preempt) state_nxt = PEND;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CP or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Acknowledge clear beats a simultaneous request; it re-latches on the next edge.
  always_ff @(posedge CP or negedge RESET_N) begin
    if (!RESET_N) begin
      pend   <= '0;
      mask   <= '1;
      iack_q <= '0;
    end else begin
      pend   <= (pend | IRQ) & ~(ack ? id_onehot(win_id) : '0);
      iack_q <= ack ? id_onehot(win_id) : '0;
      if (MASK_WE) mask <= MASK_IN;
    end
  end

  always_ff @(posedge CP or negedge RESET_N) begin
    if (!RESET_N) begin
      active_vld <= 1'b0;
      active_id  <= '0;
    end else if (ack) begin
      active_vld <= 1'b1;
      active_id  <= win_id;
    end else if (state_nxt == IDLE || (state == SERVICE && EOI)) begin
      active_vld <= 1'b0;
      active_id  <= '0;
    end
  end

endmodule

// File: doc/vector_interrupt_ctrl.md
VECTOR_INTERRUPT_CTRL -- requirements
Module: vector_interrupt_ctrl

Interface
REQ-001 SHALL have parameter VEC_BASE, default 2'b10: upper two bits of every generated interrupt vector.
REQ-002 SHALL have port CP, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port RESET_N, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port IRQ, input, 4 bits: level interrupt requests, active-high; bit 0 has the highest fixed priority.
REQ-005 SHALL have port MASK_WE, input, 1 bit: when high, loads MASK_IN into the mask register.
REQ-006 SHALL have port MASK_IN, input, 4 bits: new mask value; a 1 masks that request.
REQ-007 SHALL have ports PL_N, MAP_N and VECT_N, inputs, 1 bit each: active-low D-source enables from the sequencer.
REQ-008 SHALL have ports PIPE_D and MAP_D, inputs, 4 bits each: pipeline-register field and mapping-PROM field.
REQ-009 SHALL have port EOI, input, 1 bit: end-of-interrupt strobe from a microcode field.
REQ-010 SHALL have port D_OUT, output, 4 bits: value driven to the sequencer 4-bit D input.
REQ-011 SHALL have port CC_N, output, 1 bit: sequencer condition input; low means an interrupt is pending and the test passes.
REQ-012 SHALL have port IACK, output, 4 bits: one-hot, single-cycle acknowledge pulse.
REQ-013 SHALL have port ACTIVE, output, 3 bits: {valid, id[1:0]} of the interrupt in service.

Function
REQ-014 SHALL set pend[i] on every clock with IRQ[i]=1; masked bits still latch.
REQ-015 SHALL clear pend[i] only on the acknowledge edge for i.
REQ-016 Eligible set SHALL be pend & ~mask; requests with id numerically greater than or equal to the active id SHALL also be excluded while in SERVICE.
REQ-017 SHALL implement states IDLE, PEND and SERVICE.
REQ-018 IDLE SHALL go to PEND when the eligible set is non-empty.
REQ-019 PEND SHALL go to SERVICE on a clock edge with VECT_N=0.
REQ-020 PEND SHALL return to IDLE if the eligible set empties, e.g. when a mask write removes it.
REQ-021 In SERVICE, EOI SHALL go to PEND if a request is eligible after the active id clears, else to IDLE.
REQ-022 CC_N SHALL be low, combinationally, exactly when state is PEND and the eligible set is non-empty.
REQ-023 D_OUT SHALL be combinational, with priority PL_N > MAP_N > VECT_N when more than one enable is low.
REQ-024 D_OUT SHALL be PIPE_D when PL_N=0.
REQ-025 D_OUT SHALL be MAP_D when MAP_N=0.
REQ-026 D_OUT SHALL be {VEC_BASE, winner id} when VECT_N=0 in PEND.
REQ-027 D_OUT SHALL be 4'h0 when VECT_N=0 outside PEND, and when no enable is low.
REQ-028 The PEND->SERVICE edge SHALL pulse IACK[winner] high for exactly the following cycle, clear pend[winner] and load ACTIVE={1,winner}.
REQ-029 The winner SHALL be the value shown on D_OUT in the same cycle.
REQ-030 A MASK_WE write SHALL take effect from the next cycle; an edge with MASK_WE and VECT_N both high SHALL use the old mask.
REQ-031 When IRQ[i] is high on the acknowledge edge of i, clear SHALL win and pend[i] SHALL re-set on the next sampled edge.
REQ-032 EOI outside SERVICE SHALL be ignored.
REQ-033 EOI and VECT_N=0 on the same edge in SERVICE SHALL process EOI only.
REQ-034 A new winner SHALL be acknowledged no earlier than one cycle after EOI.
REQ-035 Latency SHALL be: IRQ edge -> pend next cycle -> PEND next cycle, so CC_N falls 2 cycles after the IRQ edge.

Reset
REQ-036 RESET_N=0 SHALL asynchronously force state IDLE, pend=4'h0, mask=4'hF (all masked), ACTIVE=3'b000, IACK=4'h0 and CC_N=1.
REQ-037 Reset during SERVICE SHALL discard the active interrupt with no IACK.
REQ-038 D_OUT SHALL follow its mux rules during reset, with no vector output.

Configuration
REQ-039 With macro VI_ROUND_ROBIN_EN defined, the winner SHALL be the first eligible id searched cyclically from (last acknowledged id + 1).
REQ-040 The last-acknowledged id SHALL reset to 3, so id 0 is searched first.
REQ-041 The nesting exclusion of REQ-016 SHALL be disabled when VI_ROUND_ROBIN_EN is defined.
REQ-042 Without VI_ROUND_ROBIN_EN, arbitration SHALL be fixed priority with the lowest id winning, and nesting SHALL be enabled.

Structure
REQ-043 Package vi_pkg SHALL hold the state enum (IDLE, PEND, SERVICE), NUM_IRQ=4 and ID_W=2.
REQ-044 Sub-module vi_prio_pick SHALL hold the combinational winner selection: eligible mask plus start id in, valid plus id out.

Verification
REQ-045 Reset, MASK_IN=4'h0 written, IRQ=4'b0100 -> CC_N low 2 cycles later; VECT_N=0 -> D_OUT=4'hA; next cycle IACK=4'b0100, ACTIVE=3'b110.
REQ-046 IRQ=4'b1010 at the same time, fixed priority -> first vector 4'h9, then after EOI 4'hB, with IACK pulses 4'b0010 then 4'b1000.
REQ-047 Nesting: id 2 in service, IRQ[0] rises -> CC_N low, vector 4'h8, ACTIVE=3'b100; IRQ[3] while id 2 is active -> CC_N stays high until EOI.
REQ-048 PL_N=0 and VECT_N=0 with PIPE_D=4'h5 -> D_OUT=4'h5, no IACK; MAP_N=0 alone with MAP_D=4'h3 -> D_OUT=4'h3.
REQ-049 Mask all (4'hF) while in PEND -> state IDLE, CC_N high; VECT_N=0 -> D_OUT=4'h0, no IACK.
REQ-050 RESET_N low during SERVICE -> immediately ACTIVE=0, CC_N=1; pend cleared; mask=4'hF after release.
